// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-to-1 registered selector.
package mux_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Channel index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request found scanning ptr, ptr+1, ... modulo CH.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int CH = 4,
  localparam int IW = idx_w(CH)
) (
  input  logic [CH-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [CH-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int   k;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < CH; i++) begin
      k = (int'(ptr_i) + i) % CH;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 selector: fixed select or round-robin, one word per cycle,
// valid/ready on every channel and on the output.
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int CH   = 4,
  parameter int MODE = MODE_FIXED
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [CH*SIZE-1:0]    data_i,
  input  logic [CH-1:0]         valid_i,
  output logic [CH-1:0]         ready_o,
  input  logic [$clog2(CH)-1:0] select_i,
  output logic [SIZE-1:0]       data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [$clog2(CH)-1:0] grant_o
);

  localparam int IW = idx_w(CH);

  // Handshake: a word moves across an interface on a rising edge where its
  // valid and ready are both high; a producer holds its word while valid is
  // high and ready is low. ready_o never depends on data, only on valid_i,
  // select_i, ready_i and registered state.

  logic [SIZE-1:0] chan [CH];
  logic [SIZE-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [CH-1:0]   sel_req, req;
  logic [CH-1:0]   win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            load_en;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    assign chan[g] = data_i[g*SIZE +: SIZE];
  end

  // Out-of-range select (non-power-of-two CH) raises no request.
  always_comb begin
    sel_req = '0;
    if (int'(select_i) < CH) sel_req[select_i] = valid_i[select_i];
  end

  assign req = (MODE == MODE_RR) ? valid_i : sel_req;

  rr_arbiter #(.CH(CH)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign load_en = !valid_q || ready_i;
  assign ready_o = load_en ? win_oh : '0;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (win_any) begin
        data_d  = chan[win_idx];
        valid_d = 1'b1;
        grant_d = win_idx;
        if (MODE == MODE_RR) ptr_d = (win_idx == IW'(CH-1)) ? '0 : win_idx + IW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: one fixed-select and one round-robin instance, CH=4, SIZE=8.
module tb_mux_arb_nto1;

  localparam int SIZE = 8;
  localparam int CH   = 4;
  localparam int W    = SIZE + 2;

  logic              clk, rst_n;
  logic [CH*SIZE-1:0] data0, data1;
  logic [CH-1:0]     valid0, valid1, rdy0, rdy1;
  logic [1:0]        sel0, sel1, grant0, grant1;
  logic [SIZE-1:0]   q0, q1;
  logic              v0, v1, ri0, ri1;

  mux_arb_nto1 #(.SIZE(SIZE), .CH(CH), .MODE(0)) u_fix (
    .clk_i(clk), .rst_n(rst_n), .data_i(data0), .valid_i(valid0), .ready_o(rdy0),
    .select_i(sel0), .data_o(q0), .valid_o(v0), .ready_i(ri0), .grant_o(grant0)
  );

  mux_arb_nto1 #(.SIZE(SIZE), .CH(CH), .MODE(1)) u_rr (
    .clk_i(clk), .rst_n(rst_n), .data_i(data1), .valid_i(valid1), .ready_o(rdy1),
    .select_i(sel1), .data_o(q1), .valid_o(v1), .ready_i(ri1), .grant_o(grant1)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic        rdy;
    logic [31:0] data;
    logic [3:0]  exp_rdy;
  } vec_t;

  vec_t            tbl [12];
  logic [W-1:0]    exp_q0[$];
  logic [W-1:0]    exp_q1[$];
  logic            m_valid [2];
  logic [SIZE-1:0] m_data  [2];
  logic [1:0]      m_grant [2];
  int              n_vec, n_err;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic clear_models();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_grant[i] = '0;
    end
  endtask

  // One cycle: drive the active instance, idle the other, check ready_o, clock, check outputs.
  task automatic do_cycle(input bit m, input logic [1:0] sel, input logic [3:0] vld,
                          input logic rdy, input logic [31:0] dat, input logic [3:0] exp_rdy);
    logic [W-1:0] e;
    logic [1:0]   ix;
    logic         r;
    if (!m) begin
      data0 = dat; sel0 = sel; valid0 = vld; ri0 = rdy;
      data1 = $urandom; sel1 = '0; valid1 = '0; ri1 = 1'b1;
    end else begin
      data1 = dat; sel1 = sel; valid1 = vld; ri1 = rdy;
      data0 = $urandom; sel0 = '0; valid0 = '0; ri0 = 1'b1;
    end
    #2;
    chk($sformatf("ready_o mode%0d", m), m ? 32'(rdy1) : 32'(rdy0), 32'(exp_rdy));
    chk("ready_o idle", m ? 32'(rdy0) : 32'(rdy1), 32'd0);
    if (exp_rdy != 4'd0) begin
      ix = oh2idx(exp_rdy);
      e  = {ix, dat[ix*SIZE +: SIZE]};
      if (!m) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      r = (i == int'(m)) ? rdy : 1'b1;
      if (i == int'(m) && exp_rdy != 4'd0) begin
        if (i == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        m_valid[i] = 1'b1;
        m_grant[i] = e[W-1:SIZE];
        m_data[i]  = e[SIZE-1:0];
      end else if (!m_valid[i] || r) begin
        m_valid[i] = 1'b0;
      end
    end
    chk($sformatf("data_o mode%0d", m),  m ? 32'(q1) : 32'(q0), 32'(m_data[m]));
    chk($sformatf("valid_o mode%0d", m), m ? 32'(v1) : 32'(v0), 32'(m_valid[m]));
    chk($sformatf("grant_o mode%0d", m), m ? 32'(grant1) : 32'(grant0), 32'(m_grant[m]));
    chk("valid_o idle", m ? 32'(v0) : 32'(v1), 32'(m_valid[!m]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst data_o fix", 32'(q0), 32'd0);
    chk("rst valid_o fix", 32'(v0), 32'd0);
    chk("rst grant_o fix", 32'(grant0), 32'd0);
    chk("rst data_o rr", 32'(q1), 32'd0);
    chk("rst valid_o rr", 32'(v1), 32'd0);
    chk("rst grant_o rr", 32'(grant1), 32'd0);
    clear_models();
    valid0 = '0; valid1 = '0; ri0 = 1'b1; ri1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    data0 = '0; data1 = '0; valid0 = '0; valid1 = '0;
    sel0 = '0; sel1 = '0; ri0 = 1'b1; ri1 = 1'b1;
    clear_models();

    tbl[0]  = '{2'd2, 4'b0100, 1'b1, 32'h00A5_0000, 4'b0100};
    tbl[1]  = '{2'd1, 4'b1101, 1'b1, 32'h1122_3344, 4'b0000};
    tbl[2]  = '{2'd3, 4'b1000, 1'b0, 32'hDEAD_BEEF, 4'b1000};
    tbl[3]  = '{2'd0, 4'b0001, 1'b0, 32'h0102_0304, 4'b0000};
    tbl[4]  = '{2'd0, 4'b0001, 1'b0, 32'h0102_0304, 4'b0000};
    tbl[5]  = '{2'd0, 4'b0001, 1'b0, 32'h0102_0304, 4'b0000};
    tbl[6]  = '{2'd0, 4'b0001, 1'b1, 32'h0102_0304, 4'b0001};
    tbl[7]  = '{2'd0, 4'b1111, 1'b1, 32'hCAFE_F00D, 4'b0001};
    tbl[8]  = '{2'd3, 4'b0111, 1'b1, 32'h55AA_55AA, 4'b0000};
    tbl[9]  = '{2'd1, 4'b0010, 1'b1, 32'h9988_7766, 4'b0010};
    tbl[10] = '{2'd2, 4'b1011, 1'b1, 32'h1357_9BDF, 4'b0000};
    tbl[11] = '{2'd3, 4'b1111, 1'b1, 32'h8070_6050, 4'b1000};

    @(posedge clk);
    #1;
    do_reset();

    // Fixed-select table
    for (int i = 0; i < 12; i++)
      do_cycle(1'b0, tbl[i].sel, tbl[i].vld, tbl[i].rdy, tbl[i].data, tbl[i].exp_rdy);

    // Round-robin: full request set walks 0,1,2,3 and wraps to 0
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0001);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0010);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0100);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b1000);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0001);
    // Bring ptr to 3, then sparse requests skip idle channels with wrap
    do_cycle(1'b1, 2'd0, 4'b0100, 1'b1, $urandom, 4'b0100);
    do_cycle(1'b1, 2'd0, 4'b0011, 1'b1, $urandom, 4'b0001);
    do_cycle(1'b1, 2'd0, 4'b0011, 1'b1, $urandom, 4'b0010);
    do_cycle(1'b1, 2'd0, 4'b0011, 1'b1, $urandom, 4'b0001);
    // Backpressure holds ptr and output; release loads with no bubble
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0010);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b0, $urandom, 4'b0000);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b0, $urandom, 4'b0000);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0100);
    do_cycle(1'b1, 2'd0, 4'b0000, 1'b1, $urandom, 4'b0000);
    do_cycle(1'b1, 2'd0, 4'b1000, 1'b1, $urandom, 4'b1000);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0001);

    // Mid-transfer reset: ptr was 1, must restart from 0
    chk("pre-reset valid_o rr", 32'(v1), 32'd1);
    do_reset();
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0001);
    do_cycle(1'b1, 2'd0, 4'b1111, 1'b1, $urandom, 4'b0010);

    // Random fixed-select traffic with an independent expectation of ready_o
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  s;
      logic [3:0]  vv;
      logic        rr;
      logic [3:0]  er;
      s  = 2'($urandom_range(0, 3));
      vv = 4'($urandom_range(0, 15));
      rr = 1'($urandom_range(0, 1));
      er = ((!m_valid[0] || rr) && vv[s]) ? (4'b0001 << s) : 4'b0000;
      do_cycle(1'b0, s, vv, rr, $urandom, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
